seq_frame_serializer: RTL and testbench

Parallel-to-serial front end for the bit-serial pattern-detector FSMs in this codebase. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a serial output that drives a detector's `x` input directly. Back-to-back words stream with no idle gap. An optional even-parity bit is appended after each word.

---
 rtl/seq_frame_serializer.sv | 139 +++++++++++++
 tb/tb_seq_frame_serializer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_frame_serializer.sv
// MSB-first parallel-to-serial front end for bit-serial pattern detectors.
// Optional even-parity bit per frame, enabled by macro SER_PARITY_EN.
module seq_frame_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef SER_PARITY_EN
    , ST_PARITY = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SER_PARITY_EN
  logic               par_q, par_d;
`endif

  logic last_bit_c;
  logic accept_c;

  assign last_bit_c = (cnt_q == '0);
  assign accept_c   = din_valid && din_ready;

  // Output decode from state and registers only; unused encodings drive nothing.
  always_comb begin
    x         = IDLE_BIT;
    x_valid   = 1'b0;
    word_done = 1'b0;
    busy      = 1'b0;
    din_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        din_ready = 1'b1;
      end
      ST_SHIFT: begin
        x       = sr_q[WIDTH-1];
        x_valid = 1'b1;
        busy    = 1'b1;
`ifndef SER_PARITY_EN
        if (last_bit_c) begin
          word_done = 1'b1;
          din_ready = 1'b1;
        end
`endif
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        x         = par_q;
        x_valid   = 1'b1;
        busy      = 1'b1;
        word_done = 1'b1;
        din_ready = 1'b1;
      end
`endif
      default: begin
        x = IDLE_BIT;
      end
    endcase
  end

  // Next state; din_ready is only high where a reload is legal, so accept always reloads.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (last_bit_c) begin
`ifdef SER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept_c) begin
      state_d = ST_SHIFT;
      sr_d    = din;
      cnt_d   = CNT_LAST;
`ifdef SER_PARITY_EN
      par_d   = ^din;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_frame_serializer.sv
// Self-checking bench for seq_frame_serializer: bit-queue reference model plus a 1101 detector.
module tb_seq_frame_serializer;

  localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
  localparam int unsigned FRAME_LEN = W + 1;
`else
  localparam int unsigned FRAME_LEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, x, x_valid, word_done, busy;

  int checks = 0;
  int errors = 0;
  int xv_cnt = 0;

  logic exp_q[$];
  logic acc_last = 1'b0;

  logic [2:0] hist;
  logic       y;

  seq_frame_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Downstream 1101 detector fed by the serial stream.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      y    <= 1'b0;
    end else if (x_valid) begin
      hist <= {hist[1:0], x};
      y    <= ({hist, x} == 4'b1101);
    end else begin
      y <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    chk("x_valid",   32'(x_valid),   32'(n > 0));
    chk("x",         32'(x),         32'((n > 0) ? exp_q[0] : 1'b0));
    chk("word_done", 32'(word_done), 32'(n == 1));
    chk("busy",      32'(busy),      32'(n > 0));
    chk("din_ready", 32'(din_ready), 32'(n <= 1));
    if (x_valid) xv_cnt++;
  endtask

  // Reference: a frame is the word MSB-first (plus its XOR) appended to the pending bit queue.
  task automatic model_edge();
    logic acc;
    if (!rst_n) begin
      exp_q.delete();
      acc_last = 1'b0;
    end else begin
      acc = din_valid && (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(din[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^din);
`endif
      end
      acc_last = acc;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_rand();
    if (!din_valid || acc_last) begin
      din_valid = ($urandom_range(0, 3) != 0);
      din       = W'($urandom);
    end
  endtask

  initial begin
    // Reset held with din_valid high: no accept, IDLE outputs.
    din       = 8'hD0;
    din_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;

    // Single word D0 with detector integration.
    cycle();
    din_valid = 1'b0;
    xv_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      chk("det_y", 32'(y), 32'(i == 4));
    end
    chk("frame_len", 32'(xv_cnt), 32'(FRAME_LEN));

    // Back-to-back D0 then 0D.
    din       = 8'hD0;
    din_valid = 1'b1;
    cycle();
    din = 8'h0D;
    xv_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (acc_last) din_valid = 1'b0;
    end
    chk("b2b_len", 32'(xv_cnt), 32'(2 * FRAME_LEN));

    // Reset asserted after three bits of FF, then B0 sent whole.
    din       = 8'hFF;
    din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_last = 1'b0;
    check_outputs();
    cycle();
    cycle();
    rst_n     = 1'b1;
    din       = 8'hB0;
    din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    xv_cnt = 0;
    for (int i = 0; i < 12; i++) cycle();
    chk("b0_len", 32'(xv_cnt), 32'(FRAME_LEN));

    // C0 exercises a zero parity bit when enabled.
    din       = 8'hC0;
    din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    for (int i = 0; i < 11; i++) cycle();

    // Randomized streaming with occasional gaps.
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      cycle();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 12; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
